// File: rtl/sar_search.sv
// -----------------------------------------------------------------------------
// sar_search
//   Successive-approximation controller built around one external magnitude
//   comparator. The trial value drives the comparator's B operand. The unknown
//   byte on the A operand is recovered by an MSB-first binary search, which
//   sets and clears trial bits directly.
//
// Ports
//   clk     in   rising-edge clock
//   rst_n   in   asynchronous active-low reset
//   start   in   search request, sampled only while idle
//   cmp_eq  in   comparator A == trial
//   cmp_lt  in   comparator A <  trial
//   cmp_gt  in   comparator A >  trial
//   trial   out  registered trial value driven to comparator B
//   busy    out  high while searching or verifying
//   done    out  one-cycle completion pulse
//   found   out  result confirmed equal to A (held until next start)
//   err     out  comparator flags were not one-hot (held until next start)
//   result  out  recovered value (held until next start)
// -----------------------------------------------------------------------------
module sar_search #(
    parameter int WIDTH      = 8,
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             cmp_eq,
    input  logic             cmp_lt,
    input  logic             cmp_gt,
    output logic [WIDTH-1:0] trial,
    output logic             busy,
    output logic             done,
    output logic             found,
    output logic             err,
    output logic [WIDTH-1:0] result
);

    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SEARCH = 2'd1;
    localparam logic [1:0] S_VERIFY = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    logic [1:0]       state_q,  state_d;
    logic [WIDTH-1:0] trial_q,  trial_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [IW-1:0]    idx_q,    idx_d;
    logic             busy_q,   busy_d;
    logic             done_q,   done_d;
    logic             found_q,  found_d;
    logic             err_q,    err_d;

    logic [2:0] flags;
    logic       flags_ok;

    assign flags    = {cmp_eq, cmp_lt, cmp_gt};
    assign flags_ok = (flags == 3'b100) || (flags == 3'b010) || (flags == 3'b001);

    always_comb begin
        state_d  = state_q;
        trial_d  = trial_q;
        result_d = result_q;
        idx_d    = idx_q;
        found_d  = found_q;
        err_d    = err_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d            = S_SEARCH;
                    trial_d            = '0;
                    trial_d[WIDTH-1]   = 1'b1;
                    idx_d              = IW'(WIDTH - 1);
                    found_d            = 1'b0;
                    err_d              = 1'b0;
                    result_d           = '0;
                end
            end

            S_SEARCH: begin
                if (!flags_ok) begin
                    state_d  = S_DONE;
                    err_d    = 1'b1;
                    found_d  = 1'b0;
                    result_d = trial_q;
                end else if (cmp_eq && EARLY_EXIT) begin
                    state_d  = S_DONE;
                    found_d  = 1'b1;
                    result_d = trial_q;
                end else begin
                    // A below the trial: this bit overshoots, so drop it.
                    // gt (and eq without early exit) keep the bit.
                    if (cmp_lt) begin
                        trial_d[idx_q] = 1'b0;
                    end
                    if (idx_q != '0) begin
                        trial_d[idx_q - IW'(1)] = 1'b1;
                        idx_d                   = idx_q - IW'(1);
                    end else begin
                        state_d = S_VERIFY;
                    end
                end
            end

            S_VERIFY: begin
                state_d  = S_DONE;
                result_d = trial_q;
                found_d  = cmp_eq;
                err_d    = !flags_ok;
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Status outputs are registered from the next state so they line up
        // with the state they describe.
        busy_d = (state_d == S_SEARCH) || (state_d == S_VERIFY);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            trial_q  <= '0;
            result_q <= '0;
            idx_q    <= IW'(WIDTH - 1);
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            found_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            trial_q  <= trial_d;
            result_q <= result_d;
            idx_q    <= idx_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            found_q  <= found_d;
            err_q    <= err_d;
        end
    end

    assign trial  = trial_q;
    assign result = result_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign found  = found_q;
    assign err    = err_q;

endmodule

// File: tb/tb_sar_search.sv
// -----------------------------------------------------------------------------
// tb_sar_search
//   Directed bench for sar_search. Two instances share clock and reset: one
//   with early exit on eq and one that always runs the full search followed by
//   the verify cycle. Each instance has its own behavioural comparator. A
//   flag-override path can inject invalid flag patterns.
//   Latency is counted with the start edge as cycle 1.
// -----------------------------------------------------------------------------
module tb_sar_search;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    // early-exit instance
    logic       start_e = 1'b0;
    logic [7:0] a_e = 8'h00;
    logic       frc_e = 1'b0;
    logic [2:0] frc_flags_e = 3'b000;
    logic       eq_e, lt_e, gt_e;
    logic [7:0] trial_e, result_e;
    logic       busy_e, done_e, found_e, err_e;

    // full-search instance
    logic       start_f = 1'b0;
    logic [7:0] a_f = 8'h00;
    logic       frc_f = 1'b0;
    logic [2:0] frc_flags_f = 3'b000;
    logic       eq_f, lt_f, gt_f;
    logic [7:0] trial_f, result_f;
    logic       busy_f, done_f, found_f, err_f;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    assign {eq_e, lt_e, gt_e} = frc_e ? frc_flags_e
                                      : {a_e == trial_e, a_e < trial_e, a_e > trial_e};
    assign {eq_f, lt_f, gt_f} = frc_f ? frc_flags_f
                                      : {a_f == trial_f, a_f < trial_f, a_f > trial_f};

    sar_search #(.WIDTH(8), .EARLY_EXIT(1'b1)) u_ee (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start_e),
        .cmp_eq (eq_e),
        .cmp_lt (lt_e),
        .cmp_gt (gt_e),
        .trial  (trial_e),
        .busy   (busy_e),
        .done   (done_e),
        .found  (found_e),
        .err    (err_e),
        .result (result_e)
    );

    sar_search #(.WIDTH(8), .EARLY_EXIT(1'b0)) u_full (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start_f),
        .cmp_eq (eq_f),
        .cmp_lt (lt_f),
        .cmp_gt (gt_f),
        .trial  (trial_f),
        .busy   (busy_f),
        .done   (done_f),
        .found  (found_f),
        .err    (err_f),
        .result (result_f)
    );

    // Selected-instance view used by the run task.
    logic       sel = 1'b0;
    logic [7:0] m_trial, m_result;
    logic       m_busy, m_done, m_found, m_err;

    assign m_trial  = sel ? trial_f  : trial_e;
    assign m_result = sel ? result_f : result_e;
    assign m_busy   = sel ? busy_f   : busy_e;
    assign m_done   = sel ? done_f   : done_e;
    assign m_found  = sel ? found_f  : found_e;
    assign m_err    = sel ? err_f    : err_e;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_start(input logic v);
        if (sel) start_f = v;
        else     start_e = v;
    endtask

    task automatic set_force(input logic v);
        if (sel) begin frc_f = v; frc_flags_f = 3'b000; end
        else     begin frc_e = v; frc_flags_e = 3'b000; end
    endtask

    // Launch one search and check the trial sequence (including the VERIFY
    // trial when present), latency and final status. force_step / poke_step
    // of 0 mean "not used"; otherwise they name the search step (1-based) at
    // which flags are forced to 000 or a stray start pulse is applied.
    task automatic run(input string tag, input logic s, input logic [7:0] a,
                       input int force_step, input int poke_step,
                       input int exp_n, input logic [7:0] exp_t [9],
                       input int exp_lat, input logic [7:0] exp_res,
                       input logic exp_found, input logic exp_err);
        logic [7:0] got [12];
        int         n;
        int         lat;
        logic       seen;
        sel  = s;
        n    = 0;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) got[i] = 8'h00;
        @(negedge clk);
        if (s) a_f = a; else a_e = a;
        set_start(1'b1);
        @(posedge clk);
        #1;
        lat = 1;
        got[n] = m_trial;
        n++;
        for (int c = 0; c < 40; c++) begin
            if (n == force_step) set_force(1'b1);
            set_start(n == poke_step);
            @(posedge clk);
            lat++;
            #1;
            if (m_done) begin
                seen = 1'b1;
                break;
            end
            if (m_busy && n < 12) begin
                got[n] = m_trial;
                n++;
            end
        end
        set_force(1'b0);
        set_start(1'b0);
        if (!seen) lat = 999;
        chk({tag, " latency"}, lat, exp_lat);
        chk({tag, " trial count"}, n, exp_n);
        for (int i = 0; i < exp_n && i < 9; i++)
            chk($sformatf("%s trial[%0d]", tag, i), got[i], exp_t[i]);
        chk({tag, " result"}, m_result, exp_res);
        chk({tag, " found"}, m_found, exp_found);
        chk({tag, " err"}, m_err, exp_err);
        chk({tag, " busy at done"}, m_busy, 1'b0);
        // let DONE return to IDLE
        @(posedge clk);
        #1;
        chk({tag, " done pulse width"}, m_done, 1'b0);
    endtask

    logic       done_seen;

    initial begin
        // ---------------- reset state ----------------
        #12;
        chk("rst trial_e",  trial_e,  8'h00);
        chk("rst result_e", result_e, 8'h00);
        chk("rst busy_e",   busy_e,   1'b0);
        chk("rst done_e",   done_e,   1'b0);
        chk("rst found_e",  found_e,  1'b0);
        chk("rst err_e",    err_e,    1'b0);
        chk("rst trial_f",  trial_f,  8'h00);
        chk("rst busy_f",   busy_f,   1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // ---------------- early-exit searches ----------------
        run("ee 12", 1'b0, 8'h12, 0, 0, 7,
            '{8'h80, 8'h40, 8'h20, 8'h10, 8'h18, 8'h14, 8'h12, 8'h00, 8'h00},
            8, 8'h12, 1'b1, 1'b0);
        run("ee 80", 1'b0, 8'h80, 0, 0, 1,
            '{8'h80, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
            2, 8'h80, 1'b1, 1'b0);
        run("ee 00", 1'b0, 8'h00, 0, 0, 9,
            '{8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h00},
            10, 8'h00, 1'b1, 1'b0);
        run("ee FF", 1'b0, 8'hFF, 0, 0, 8,
            '{8'h80, 8'hC0, 8'hE0, 8'hF0, 8'hF8, 8'hFC, 8'hFE, 8'hFF, 8'h00},
            9, 8'hFF, 1'b1, 1'b0);

        // ---------------- full-search instance ----------------
        run("full FF", 1'b1, 8'hFF, 0, 0, 9,
            '{8'h80, 8'hC0, 8'hE0, 8'hF0, 8'hF8, 8'hFC, 8'hFE, 8'hFF, 8'hFF},
            10, 8'hFF, 1'b1, 1'b0);
        // eq at step 7 keeps the bit; step 8 tries 13, lt clears bit 0
        run("full 12", 1'b1, 8'h12, 0, 0, 9,
            '{8'h80, 8'h40, 8'h20, 8'h10, 8'h18, 8'h14, 8'h12, 8'h13, 8'h12},
            10, 8'h12, 1'b1, 1'b0);

        // ---------------- invalid flags, then recovery ----------------
        run("flags000", 1'b0, 8'h30, 2, 0, 2,
            '{8'h80, 8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
            3, 8'h40, 1'b0, 1'b1);
        run("after err", 1'b0, 8'h55, 0, 0, 8,
            '{8'h80, 8'h40, 8'h60, 8'h50, 8'h58, 8'h54, 8'h56, 8'h55, 8'h00},
            9, 8'h55, 1'b1, 1'b0);

        // ---------------- start held high across done ----------------
        sel = 1'b0;
        @(negedge clk);
        a_e = 8'h80;
        start_e = 1'b1;
        @(posedge clk); #1;            // start edge, SEARCH trial 80
        @(posedge clk); #1;            // eq sampled -> DONE
        chk("held done", done_e, 1'b1);
        chk("held busy in done", busy_e, 1'b0);
        @(posedge clk); #1;            // start ignored in DONE -> IDLE
        chk("held idle busy", busy_e, 1'b0);
        chk("held idle done", done_e, 1'b0);
        @(posedge clk); #1;            // start sampled in IDLE -> relaunch
        chk("held relaunch busy", busy_e, 1'b1);
        chk("held relaunch trial", trial_e, 8'h80);
        start_e = 1'b0;
        repeat (4) @(posedge clk);
        #1;

        // ---------------- reset mid-search ----------------
        @(negedge clk);
        a_e = 8'h12;
        start_e = 1'b1;
        @(posedge clk); #1;            // SEARCH cycle 1
        start_e = 1'b0;
        @(posedge clk); #1;            // cycle 2
        @(posedge clk); #1;            // cycle 3
        @(posedge clk); #1;            // cycle 4, trial 10
        chk("pre-reset trial", trial_e, 8'h10);
        rst_n = 1'b0;
        #1;
        chk("mid rst trial",  trial_e,  8'h00);
        chk("mid rst busy",   busy_e,   1'b0);
        chk("mid rst done",   done_e,   1'b0);
        chk("mid rst found",  found_e,  1'b0);
        chk("mid rst err",    err_e,    1'b0);
        chk("mid rst result", result_e, 8'h00);
        done_seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done_e) done_seen = 1'b1;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done_e) done_seen = 1'b1;
        end
        chk("no done after reset", done_seen, 1'b0);

        // AA with a stray start pulse at step 3, which must be ignored
        run("AA poke", 1'b0, 8'hAA, 0, 3, 7,
            '{8'h80, 8'hC0, 8'hA0, 8'hB0, 8'hA8, 8'hAC, 8'hAA, 8'h00, 8'h00},
            8, 8'hAA, 1'b1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
